instr_mem_sync: RTL and testbench

Synchronous, parametrised instruction memory for the pipeline's fetch stage. It replaces the combinational ROM with a registered-read word array. The array is cleared to NOP by an init sweep after reset and can be loaded at run time through a program port. It has pipeline stall/flush control and flags misaligned or out-of-range fetches. It sits between the PC register and the IF/ID pipeline register.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/imem_ram.sv | 26 ++
 rtl/instr_mem_sync.sv | 120 ++++++++++++
 tb/tb_instr_mem_sync.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-stage definitions: bubble encoding, instruction-memory FSM states
// and the word-index width helper.
package pipeline_pkg;

  localparam logic [31:0] NOP_INS_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {INIT, READY} imem_state_t;

  function automatic int word_idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x INS_W word array: one write port, one read port. The read is write-first
// and is sampled by the caller's output register, giving a one-cycle synchronous read.
module imem_ram
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int INS_W = 32,
  parameter int IW    = word_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [INS_W-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [INS_W-1:0] rdata
);

  logic [INS_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/instr_mem_sync.sv
// Registered-read instruction memory for the fetch stage: NOP init sweep after reset,
// run-time program port, stall/flush control and misaligned/out-of-range fault flag.
module instr_mem_sync
  import pipeline_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                INS_W   = 32,
  parameter int                DEPTH   = 64,
  parameter logic [INS_W-1:0]  NOP_INS = INS_W'(NOP_INS_DEF)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_valid,
  input  logic [ADDR_W-1:0]            fetch_addr,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         prog_en,
  input  logic [$clog2(DEPTH)-1:0]     prog_addr,
  input  logic [INS_W-1:0]             prog_data,
  output logic                         ready,
  output logic [INS_W-1:0]             instruction,
  output logic                         instr_valid,
  output logic                         fault
);

  localparam int              IW    = word_idx_w(DEPTH);
  localparam longint unsigned LIMIT = 4 * longint'(DEPTH);

  imem_state_t      state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ready_q, ready_d;
  logic [INS_W-1:0] instruction_q, instruction_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fault_q, fault_d;

  logic             ram_we;
  logic [IW-1:0]    ram_waddr;
  logic [INS_W-1:0] ram_wdata;
  logic [INS_W-1:0] ram_rdata;
  logic             bad_addr;

  // Range check widened to 64 bits so no high address bit is truncated away.
  assign bad_addr = (fetch_addr[1:0] != 2'b00) || (64'(fetch_addr) >= 64'(LIMIT));

  imem_ram #(.DEPTH(DEPTH), .INS_W(INS_W), .IW(IW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (fetch_addr[IW+1:2]),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ready_d       = ready_q;
    instruction_d = instruction_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    ram_we        = 1'b0;
    ram_waddr     = prog_addr;
    ram_wdata     = prog_data;
    case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_waddr = idx_q;
        ram_wdata = NOP_INS;
        idx_d     = idx_q + 1'b1;
        if (idx_q == IW'(DEPTH - 1)) begin
          state_d = READY;
          ready_d = 1'b1;
          idx_d   = '0;
        end
      end
      READY: begin
        ram_we = prog_en;
        if (flush) begin
          instruction_d = NOP_INS;
          instr_valid_d = 1'b0;
          fault_d       = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (fetch_valid) begin
          instruction_d = bad_addr ? NOP_INS : ram_rdata;
          instr_valid_d = 1'b1;
          fault_d       = bad_addr;
        end else begin
          instr_valid_d = 1'b0;
          fault_d       = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      idx_q         <= '0;
      ready_q       <= 1'b0;
      instruction_q <= NOP_INS;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ready_q       <= ready_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign ready       = ready_q;
  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed plus random bench for instr_mem_sync against a cycle-level behavioural model.
module tb_instr_mem_sync;

  localparam int          DEPTH = 64;
  localparam int          IW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_valid;
  logic [31:0]   fetch_addr;
  logic          stall, flush, prog_en;
  logic [IW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          ready;
  logic [31:0]   instruction;
  logic          instr_valid, fault;

  always #5 clk = ~clk;

  instr_mem_sync #(.ADDR_W(32), .INS_W(32), .DEPTH(DEPTH), .NOP_INS(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .stall(stall), .flush(flush), .prog_en(prog_en), .prog_addr(prog_addr),
    .prog_data(prog_data), .ready(ready), .instruction(instruction),
    .instr_valid(instr_valid), .fault(fault)
  );

  // Behavioural model: init is just a cycle count; the array becomes all-NOP when it ends.
  logic [31:0] m_mem [DEPTH];
  int          m_cnt;
  bit          m_ready;
  logic [31:0] m_ins;
  bit          m_v, m_f;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    longint unsigned a;
    if (!rst_n) begin
      m_cnt = 0; m_ready = 0; m_ins = NOP; m_v = 0; m_f = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_ready = 1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
      end
    end else begin
      if (prog_en) m_mem[prog_addr] = prog_data;
      a = 64'(fetch_addr);
      if (flush) begin
        m_ins = NOP; m_v = 0; m_f = 0;
      end else if (stall) begin
      end else if (fetch_valid) begin
        m_v = 1;
        if ((a % 4) != 0 || a >= 4 * DEPTH) begin
          m_ins = NOP; m_f = 1;
        end else begin
          m_ins = m_mem[a / 4]; m_f = 0;
        end
      end else begin
        m_v = 0; m_f = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("instruction", instruction, m_ins);
    chk("instr_valid", 32'(instr_valid), 32'(m_v));
    chk("fault", 32'(fault), 32'(m_f));
  endtask

  task automatic idle();
    fetch_valid = 0; fetch_addr = '0; stall = 0; flush = 0;
    prog_en = 0; prog_addr = '0; prog_data = '0;
  endtask

  task automatic fetch(input logic [31:0] a);
    idle(); fetch_valid = 1; fetch_addr = a;
  endtask

  initial begin
    rst_n = 0; idle();
    step(); step();
    chk("reset_ins", instruction, NOP);
    rst_n = 1;
    for (int i = 0; i < DEPTH - 1; i++) step();
    chk("ready_low_at_63", 32'(ready), 32'd0);
    step();
    chk("ready_high_at_64", 32'(ready), 32'd1);

    fetch(32'h10); step();
    chk("fetch_0x10", instruction, 32'h0000_0013);
    idle(); prog_en = 1; prog_addr = 1; prog_data = 32'h0030_0113; step();
    fetch(32'h4); step();
    chk("prog_w1", instruction, 32'h0030_0113);
    fetch(32'h6); step();
    chk("misalign_fault", 32'(fault), 32'd1);
    fetch(32'h100); step();
    chk("range_fault", 32'(fault), 32'd1);
    fetch(32'hFFFF_FFFC); step();
    fetch(32'hFC); step();
    chk("last_word_ok", 32'(fault), 32'd0);

    fetch(32'h4); step();
    fetch(32'h8); stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", instruction, 32'h0030_0113);
    end
    stall = 0; step();
    fetch(32'h4); stall = 1; flush = 1; step();
    chk("flush_bubble_v", 32'(instr_valid), 32'd0);
    fetch(32'h8); prog_en = 1; prog_addr = 2; prog_data = 32'h0070_0193; step();
    chk("write_first", instruction, 32'h0070_0193);

    for (int n = 0; n < 400; n++) begin
      int r;
      idle();
      r = int'($urandom_range(0, 9));
      fetch_valid = ($urandom_range(0, 3) != 0);
      if (r == 0)      fetch_addr = $urandom();
      else if (r == 1) fetch_addr = {24'd0, 8'($urandom_range(0, 255))} | 32'd1;
      else             fetch_addr = {24'd0, 6'($urandom_range(0, 15)), 2'b00};
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      prog_en   = ($urandom_range(0, 2) == 0);
      prog_addr = IW'($urandom_range(0, 15));
      prog_data = $urandom();
      step();
    end

    // Reset in the middle of the sweep, with traffic that INIT must ignore.
    idle(); rst_n = 0; step(); rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      fetch_valid = 1; fetch_addr = 32'h4; prog_en = 1; prog_addr = 1;
      prog_data = $urandom(); step();
    end
    idle(); rst_n = 0; step();
    chk("midinit_rst_ready", 32'(ready), 32'd0);
    rst_n = 1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      fetch_valid = 1; fetch_addr = 32'h4; flush = 1; step();
    end
    chk("resweep_ready_low", 32'(ready), 32'd0);
    idle(); step();
    chk("resweep_ready_high", 32'(ready), 32'd1);
    fetch(32'h4); step();
    chk("w1_cleared", instruction, NOP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
